// File: rtl/mem_access_ctrl_pkg.sv
// Shared load/store size encodings and the alignment rule for the
// memory access controller.
package mem_access_ctrl_pkg;

   localparam logic [1:0] LOAD_STORE_BYTE = 2'd0;
   localparam logic [1:0] LOAD_STORE_HALF = 2'd1;
   localparam logic [1:0] LOAD_STORE_WORD = 2'd2;

   // A half may straddle bytes 1..2 but not the word boundary; any
   // encoding other than BYTE/HALF is treated as a full word.
   function automatic logic is_misaligned(input logic [1:0] offset,
                                          input logic [1:0] len);
      logic mis;
      case (len)
         LOAD_STORE_BYTE: mis = 1'b0;
         LOAD_STORE_HALF: mis = (offset == 2'd3);
         default:         mis = (offset != 2'd0);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_store.sv
// Alignment unit: extracts a byte/half/word from a memory word for loads
// and merges right-aligned store data into a memory word for stores.
module mem_access_ctrl_load_store
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  len_i,
   input  logic        sign_ext_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] lane_mask;

   assign shamt = {offset_i, 3'b000};

   always_comb begin
      shifted     = word_i >> shamt;
      load_data_o = word_i;
      lane_mask   = 32'hFFFF_FFFF;
      case (len_i)
         LOAD_STORE_BYTE: begin
            load_data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            lane_mask   = 32'h0000_00FF << shamt;
         end
         LOAD_STORE_HALF: begin
            load_data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            lane_mask   = 32'h0000_FFFF << shamt;
         end
         default: begin
            load_data_o = word_i;
            lane_mask   = 32'hFFFF_FFFF;
         end
      endcase
      merged_o = (word_i & ~lane_mask) | ((store_data_i << shamt) & lane_mask);
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns byte/half/word core requests into word
// reads, read-modify-writes and writes with alignment and timeout checks.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   // Core side: a request transfers on a rising edge where reqValid and
   // reqReady are both high; respValid is a single-cycle completion pulse.
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [31:0] reqAddr,
   input  logic [1:0]  reqLen,
   input  logic        reqSignExtend,
   input  logic [31:0] reqWriteData,
   output logic        respValid,
   output logic [31:0] respReadData,
   output logic        respError,
   // Memory side: a strobe is held until memAck completes that phase.
   output logic [29:0] memAddr,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData,
   input  logic        memAck,
   output logic [1:0]  dbgState
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 2);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      word_q, word_d;
   logic [1:0]       len_q, len_d;
   logic             write_q, write_d;
   logic             sext_q, sext_d;
   logic             err_q, err_d;
   logic [31:0]      load_data;
   logic [31:0]      merged_data;
   logic             timeout_hit;

   mem_access_ctrl_load_store u_load_store (
      .word_i       (word_q),
      .offset_i     (addr_q[1:0]),
      .len_i        (len_q),
      .sign_ext_i   (sext_q),
      .store_data_i (wdata_q),
      .load_data_o  (load_data),
      .merged_o     (merged_data)
   );

   // Fires on the last permitted waiting cycle so the strobe is high for
   // exactly ACK_TIMEOUT cycles before the error response.
   assign timeout_hit = (ACK_TIMEOUT != 0) &&
                        (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      len_d   = len_q;
      write_d = write_q;
      sext_d  = sext_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (reqValid) begin
               addr_d  = reqAddr;
               wdata_d = reqWriteData;
               len_d   = reqLen;
               write_d = reqWrite;
               sext_d  = reqSignExtend;
               word_d  = 32'h0;
               cnt_d   = '0;
               err_d   = is_misaligned(reqAddr[1:0], reqLen);
               if (is_misaligned(reqAddr[1:0], reqLen))
                  state_d = RESP;
               else if (!reqWrite || reqLen == LOAD_STORE_BYTE ||
                        reqLen == LOAD_STORE_HALF)
                  state_d = READ;
               else
                  state_d = WRITE;
            end
         end
         READ: begin
            if (memAck) begin
               word_d  = memReadData;
               cnt_d   = '0;
               state_d = write_q ? WRITE : RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WRITE: begin
            if (memAck) begin
               state_d = RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
         len_q   <= 2'd0;
         write_q <= 1'b0;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         len_q   <= len_d;
         write_q <= write_d;
         sext_q  <= sext_d;
         err_q   <= err_d;
      end
   end

   assign dbgState     = state_q;
   assign reqReady     = (state_q == IDLE);
   assign respValid    = (state_q == RESP);
   assign respError    = (state_q == RESP) && err_q;
   assign respReadData = (state_q == RESP && !err_q && !write_q) ? load_data : 32'h0;
   assign memAddr      = addr_q[31:2];
   assign memRead      = (state_q == READ);
   assign memWrite     = (state_q == WRITE);
   assign memWriteData = (state_q == WRITE) ? merged_data : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, sub-word and word stores,
// misalignment, timeout, back-to-back requests and reset during a write.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        reqValid, reqReady, reqWrite, reqSignExtend;
   logic [31:0] reqAddr, reqWriteData;
   logic [1:0]  reqLen;
   logic        respValid, respError;
   logic [31:0] respReadData;
   logic [29:0] memAddr;
   logic        memRead, memWrite, memAck;
   logic [31:0] memWriteData, memReadData;
   logic [1:0]  dbgState;

   int checks   = 0;
   int failures = 0;

   // results of the most recent do_access
   int          r_lat, r_rd, r_wr;
   logic [31:0] r_wword, r_data;
   logic [29:0] r_addr;
   logic        r_err, r_got, r_both, r_changed;

   mem_access_ctrl #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .resetn(resetn),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqAddr(reqAddr), .reqLen(reqLen), .reqSignExtend(reqSignExtend),
      .reqWriteData(reqWriteData),
      .respValid(respValid), .respReadData(respReadData), .respError(respError),
      .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
      .memWriteData(memWriteData), .memReadData(memReadData), .memAck(memAck),
      .dbgState(dbgState)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and plays memory, acking each phase after
   // ack_delay waiting cycles. Leaves the DUT back in IDLE.
   task automatic do_access(input logic wr, input logic [31:0] addr,
                            input logic [1:0] len, input logic sext,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_delay);
      r_lat = 1; r_rd = 0; r_wr = 0; r_wword = 0; r_data = 0; r_addr = 0;
      r_err = 0; r_got = 0; r_both = 0; r_changed = 0;
      reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqLen = len;
      reqSignExtend = sext; reqWriteData = wd;
      step();
      reqValid = 1'b0; reqAddr = 32'hFFFF_FFFF; reqWriteData = 32'h5555_5555;
      for (int c = 0; c < 40; c++) begin
         if (memRead && memWrite) r_both = 1'b1;
         if (respValid) begin
            r_got = 1'b1; r_data = respReadData; r_err = respError;
            break;
         end
         memAck = 1'b0;
         if (memRead || memWrite) begin
            if (r_rd + r_wr == 0) r_addr = memAddr;
            else if (memAddr !== r_addr) r_changed = 1'b1;
         end
         if (memRead) begin
            r_rd++;
            memReadData = rd;
            memAck = (r_rd > ack_delay);
         end
         if (memWrite) begin
            if (r_wr > 0 && memWriteData !== r_wword) r_changed = 1'b1;
            r_wr++;
            r_wword = memWriteData;
            memAck = (r_wr > ack_delay);
         end
         step();
         r_lat++;
      end
      memAck = 1'b0; memReadData = 32'h0;
      if (r_got) step();
   endtask

   task automatic test_reset();
      resetn = 1'b0; memAck = 1'b1; memReadData = 32'hFFFF_FFFF;
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h123; reqLen = LOAD_STORE_WORD;
      step(); step();
      checks++; if (reqReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", reqReady); end
      checks++; if (respValid !== 1'b0 || respError !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b%b exp=00", respValid, respError); end
      checks++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", memRead, memWrite); end
      checks++; if (respReadData !== 32'h0 || memWriteData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", respReadData, memWriteData); end
      checks++; if (memAddr !== 30'h0 || dbgState !== 2'd0) begin failures++; $display("FAIL reset_addr_state got=%h/%0d exp=0/0", memAddr, dbgState); end
      reqValid = 1'b0; memAck = 1'b0; memReadData = 32'h0; resetn = 1'b1;
      step();
   endtask

   task automatic test_loads();
      do_access(1'b0, 32'h103, LOAD_STORE_BYTE, 1'b1, 32'h0, 32'h80AB_CD12, 0);
      checks++; if (r_data !== 32'hFFFF_FF80 || r_err !== 1'b0) begin failures++; $display("FAIL lb_data got=%h err=%b exp=ffffff80 err=0", r_data, r_err); end
      checks++; if (r_lat !== 2 || r_addr !== 30'h40) begin failures++; $display("FAIL lb_lat_addr got=%0d/%h exp=2/40", r_lat, r_addr); end
      checks++; if (r_rd !== 1 || r_wr !== 0) begin failures++; $display("FAIL lb_strobes got=rd%0d wr%0d exp=rd1 wr0", r_rd, r_wr); end
      do_access(1'b0, 32'h103, LOAD_STORE_BYTE, 1'b0, 32'h0, 32'h80AB_CD12, 0);
      checks++; if (r_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", r_data); end
      do_access(1'b0, 32'h101, LOAD_STORE_HALF, 1'b1, 32'h0, 32'h80AB_CD12, 0);
      checks++; if (r_data !== 32'hFFFF_ABCD || r_err !== 1'b0) begin failures++; $display("FAIL lh_off1 got=%h err=%b exp=ffffabcd err=0", r_data, r_err); end
      do_access(1'b0, 32'h104, LOAD_STORE_WORD, 1'b1, 32'h0, 32'h80AB_CD12, 0);
      checks++; if (r_data !== 32'h80AB_CD12 || r_addr !== 30'h41) begin failures++; $display("FAIL lw_data got=%h/%h exp=80abcd12/41", r_data, r_addr); end
      // wait states: two cycles without ack before the read completes
      do_access(1'b0, 32'h206, LOAD_STORE_HALF, 1'b0, 32'h0, 32'hCAFE_1234, 2);
      checks++; if (r_data !== 32'h0000_CAFE || r_lat !== 4 || r_rd !== 3) begin failures++; $display("FAIL lhu_wait got=%h lat=%0d rd=%0d exp=0000cafe lat=4 rd=3", r_data, r_lat, r_rd); end
      checks++; if (r_changed !== 1'b0 || r_both !== 1'b0) begin failures++; $display("FAIL lhu_wait_stable got=chg%b both%b exp=00", r_changed, r_both); end
   endtask

   task automatic test_stores();
      do_access(1'b1, 32'h202, LOAD_STORE_HALF, 1'b0, 32'h0000_BEEF, 32'h1122_3344, 0);
      checks++; if (r_wword !== 32'hBEEF_3344 || r_err !== 1'b0) begin failures++; $display("FAIL sh_merge got=%h err=%b exp=beef3344 err=0", r_wword, r_err); end
      checks++; if (r_lat !== 3 || r_rd !== 1 || r_wr !== 1 || r_data !== 32'h0) begin failures++; $display("FAIL sh_flow got=lat%0d rd%0d wr%0d d=%h exp=lat3 rd1 wr1 d=0", r_lat, r_rd, r_wr, r_data); end
      do_access(1'b1, 32'h301, LOAD_STORE_BYTE, 1'b0, 32'hFFFF_FFAA, 32'h1122_3344, 1);
      checks++; if (r_wword !== 32'h1122_AA44 || r_changed !== 1'b0) begin failures++; $display("FAIL sb_merge got=%h chg=%b exp=1122aa44 chg=0", r_wword, r_changed); end
      do_access(1'b1, 32'h10, LOAD_STORE_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 0);
      checks++; if (r_wword !== 32'hDEAD_BEEF || r_addr !== 30'h4) begin failures++; $display("FAIL sw_data got=%h/%h exp=deadbeef/4", r_wword, r_addr); end
      checks++; if (r_rd !== 0 || r_wr !== 1 || r_lat !== 2 || r_err !== 1'b0) begin failures++; $display("FAIL sw_flow got=rd%0d wr%0d lat%0d err%b exp=rd0 wr1 lat2 err0", r_rd, r_wr, r_lat, r_err); end
   endtask

   task automatic test_misaligned();
      do_access(1'b0, 32'h6, LOAD_STORE_WORD, 1'b0, 32'h0, 32'hFFFF_FFFF, 0);
      checks++; if (r_err !== 1'b1 || r_got !== 1'b1 || r_data !== 32'h0) begin failures++; $display("FAIL lw_mis got=err%b resp%b d=%h exp=err1 resp1 d=0", r_err, r_got, r_data); end
      checks++; if (r_rd !== 0 || r_wr !== 0 || r_lat !== 1) begin failures++; $display("FAIL lw_mis_flow got=rd%0d wr%0d lat%0d exp=rd0 wr0 lat1", r_rd, r_wr, r_lat); end
      do_access(1'b0, 32'h7, LOAD_STORE_HALF, 1'b1, 32'h0, 32'hFFFF_FFFF, 0);
      checks++; if (r_err !== 1'b1 || r_data !== 32'h0 || r_rd !== 0 || r_wr !== 0) begin failures++; $display("FAIL lh_mis got=err%b d=%h rd%0d wr%0d exp=err1 d=0 rd0 wr0", r_err, r_data, r_rd, r_wr); end
      do_access(1'b1, 32'h2, LOAD_STORE_WORD, 1'b0, 32'h1234_5678, 32'h0, 0);
      checks++; if (r_err !== 1'b1 || r_wr !== 0 || r_lat !== 1) begin failures++; $display("FAIL sw_mis got=err%b wr%0d lat%0d exp=err1 wr0 lat1", r_err, r_wr, r_lat); end
   endtask

   task automatic test_timeout();
      do_access(1'b1, 32'h401, LOAD_STORE_BYTE, 1'b0, 32'h77, 32'h0, 100);
      checks++; if (r_rd !== 4 || r_wr !== 0) begin failures++; $display("FAIL timeout_strobes got=rd%0d wr%0d exp=rd4 wr0", r_rd, r_wr); end
      checks++; if (r_err !== 1'b1 || r_got !== 1'b1 || r_lat !== 5) begin failures++; $display("FAIL timeout_resp got=err%b resp%b lat%0d exp=err1 resp1 lat5", r_err, r_got, r_lat); end
      do_access(1'b1, 32'h8, LOAD_STORE_WORD, 1'b0, 32'h1, 32'h0, 100);
      checks++; if (r_wr !== 4 || r_err !== 1'b1) begin failures++; $display("FAIL wr_timeout got=wr%0d err%b exp=wr4 err1", r_wr, r_err); end
   endtask

   task automatic test_back_to_back();
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h6; reqLen = LOAD_STORE_WORD; reqSignExtend = 1'b0;
      step();
      checks++; if (respValid !== 1'b1 || reqReady !== 1'b0) begin failures++; $display("FAIL b2b_resp got=v%b r%b exp=v1 r0", respValid, reqReady); end
      step();
      checks++; if (respValid !== 1'b0 || reqReady !== 1'b1) begin failures++; $display("FAIL b2b_idle got=v%b r%b exp=v0 r1", respValid, reqReady); end
      step();
      checks++; if (respValid !== 1'b1 || respError !== 1'b1) begin failures++; $display("FAIL b2b_second got=v%b e%b exp=v1 e1", respValid, respError); end
      reqValid = 1'b0;
      step();
   endtask

   task automatic test_ack_outside();
      int bad = 0;
      memAck = 1'b1; memReadData = 32'hFFFF_FFFF;
      for (int c = 0; c < 4; c++) begin
         step();
         if (respValid !== 1'b0 || reqReady !== 1'b1 || memRead !== 1'b0 || memWrite !== 1'b0) bad++;
      end
      memAck = 1'b0; memReadData = 32'h0;
      checks++; if (bad !== 0) begin failures++; $display("FAIL idle_ack got=%0d bad cycles exp=0", bad); end
   endtask

   task automatic test_reset_mid_write();
      int bad = 0;
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h20; reqLen = LOAD_STORE_WORD; reqWriteData = 32'hA5A5_A5A5;
      step();
      reqValid = 1'b0;
      checks++; if (memWrite !== 1'b1 || memWriteData !== 32'hA5A5_A5A5) begin failures++; $display("FAIL rst_wr_pre got=%b/%h exp=1/a5a5a5a5", memWrite, memWriteData); end
      resetn = 1'b0;
      step();
      checks++; if (memWrite !== 1'b0 || respValid !== 1'b0 || reqReady !== 1'b1) begin failures++; $display("FAIL rst_wr_post got=w%b v%b r%b exp=w0 v0 r1", memWrite, respValid, reqReady); end
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         if (respValid !== 1'b0 || memWrite !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rst_wr_after got=%0d bad cycles exp=0", bad); end
   endtask

   initial begin
      resetn = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 32'h0;
      reqLen = LOAD_STORE_BYTE; reqSignExtend = 1'b0; reqWriteData = 32'h0;
      memAck = 1'b0; memReadData = 32'h0;
      test_reset();
      test_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_ack_outside();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
